board_mem: RTL

BOARD_MEM -- requirements
Module: board_mem

---
 rtl/board_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 27 ++
 rtl/board_mem.sv | 118 +++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared definitions for the game board memory: board geometry defaults,
// field widths, cell encodings and the controller state type.
package board_pkg;

    localparam int WIDTH_DEF  = 6;
    localparam int HEIGHT_DEF = 6;
    localparam int COORD_W    = 3;
    localparam int CELL_W     = 2;

    localparam logic [CELL_W-1:0] CELL_EMPTY = 2'b00;
    localparam logic [CELL_W-1:0] CELL_SHIP  = 2'b01;
    localparam logic [CELL_W-1:0] CELL_MARK  = 2'b10;
    localparam logic [CELL_W-1:0] CELL_HIT   = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. Grants are combinational; the priority
// flag only moves on a contested grant and then points at the losing port.
module rr_arbiter2 (
    input  logic clk,
    input  logic rstn,
    input  logic enable,
    input  logic req_a,
    input  logic req_b,
    output logic grant_a,
    output logic grant_b
);

    logic prio_b;

    assign grant_a = enable && req_a && (!req_b || !prio_b);
    assign grant_b = enable && req_b && (!req_a || prio_b);

    // Winner always held priority, so flipping hands it to the loser.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prio_b <= 1'b0;
        end else if (enable && req_a && req_b) begin
            prio_b <= !prio_b;
        end
    end

endmodule

// File: rtl/board_mem.sv
// Dual-port board cell memory shared by the search engine (A) and the game
// controller (B), with a one-cell-per-cycle whole-board clear sweep.
module board_mem
    import board_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int HEIGHT = HEIGHT_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [COORD_W-1:0] a_addr_x,
    input  logic [COORD_W-1:0] a_addr_y,
    input  logic [CELL_W-1:0]  a_wr_data,
    input  logic               a_wr_en,
    input  logic               a_in_valid,
    output logic               a_ready,
    output logic [CELL_W-1:0]  a_rd_data,
    input  logic [COORD_W-1:0] b_addr_x,
    input  logic [COORD_W-1:0] b_addr_y,
    input  logic [CELL_W-1:0]  b_wr_data,
    input  logic               b_wr_en,
    input  logic               b_in_valid,
    output logic               b_ready,
    output logic [CELL_W-1:0]  b_rd_data,
    input  logic               clr_start,
    output logic               clr_busy,
    output logic               clr_done
);

    localparam int CELLS = WIDTH * HEIGHT;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    logic [CELL_W-1:0]  cells [CELLS];
    state_t             state;
    logic [IDX_W-1:0]   clr_idx;

    logic               serve_en;
    logic               grant_a;
    logic               grant_b;
    logic [COORD_W-1:0] sel_x;
    logic [COORD_W-1:0] sel_y;
    logic               sel_we;
    logic [CELL_W-1:0]  sel_wd;
    logic               sel_in_range;
    logic [IDX_W-1:0]   sel_idx;
    logic [CELL_W-1:0]  sel_rd;

    // A clear request in IDLE takes precedence over any port access.
    assign serve_en = (state == ST_IDLE) && !clr_start;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .enable  (serve_en),
        .req_a   (a_in_valid),
        .req_b   (b_in_valid),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    always_comb begin
        sel_x        = grant_b ? b_addr_x  : a_addr_x;
        sel_y        = grant_b ? b_addr_y  : a_addr_y;
        sel_we       = grant_b ? b_wr_en   : a_wr_en;
        sel_wd       = grant_b ? b_wr_data : a_wr_data;
        sel_in_range = (int'(sel_x) < WIDTH) && (int'(sel_y) < HEIGHT);
        sel_idx      = IDX_W'(int'(sel_y) * WIDTH + int'(sel_x));
        sel_rd       = sel_in_range ? cells[sel_idx] : CELL_EMPTY;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            clr_idx   <= '0;
            clr_busy  <= 1'b0;
            clr_done  <= 1'b0;
            a_ready   <= 1'b0;
            b_ready   <= 1'b0;
            a_rd_data <= CELL_EMPTY;
            b_rd_data <= CELL_EMPTY;
            for (int i = 0; i < CELLS; i++) begin
                cells[i] <= CELL_EMPTY;
            end
        end else begin
            a_ready  <= 1'b0;
            b_ready  <= 1'b0;
            clr_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clr_start) begin
                        state    <= ST_CLEAR;
                        clr_idx  <= '0;
                        clr_busy <= 1'b1;
                    end else if (grant_a || grant_b) begin
                        a_ready <= grant_a;
                        b_ready <= grant_b;
                        if (grant_a) a_rd_data <= sel_rd;
                        if (grant_b) b_rd_data <= sel_rd;
                        // Read data was captured from the pre-write contents.
                        if (sel_we && sel_in_range) cells[sel_idx] <= sel_wd;
                    end
                end
                ST_CLEAR: begin
                    cells[clr_idx] <= CELL_EMPTY;
                    if (clr_idx == IDX_W'(CELLS - 1)) begin
                        state    <= ST_IDLE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
